// File: rtl/pkg_mpu.sv
// Shared types for the MPU dispatch controller: FSM encoding and latched dispatch request.
package pkg_mpu;

  localparam int unsigned P_NUM_TPU = 16;
  localparam int unsigned P_THID_W  = 8;
  localparam int unsigned P_LEN_W   = 10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_CMT,
    DONE
  } dispatch_fsm_t;

  typedef struct packed {
    logic [P_THID_W-1:0]  thid;
    logic [P_LEN_W-1:0]   base;
    logic [P_LEN_W-1:0]   length;
    logic [P_NUM_TPU-1:0] en_tpu;
  } dispatch_req_t;

endpackage

// File: rtl/mpu_commit_collect.sv
// Accumulates per-lane commit pulses against the dispatch lane mask and flags when all have landed.
module mpu_commit_collect #(
  parameter int unsigned NUM_TPU = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_en,
  input  logic               i_clr,
  input  logic [NUM_TPU-1:0] i_mask,
  input  logic [NUM_TPU-1:0] i_commit,
  output logic               o_all_done
);

  logic [NUM_TPU-1:0] r_cmt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cmt <= '0;
    end else if (i_clr) begin
      r_cmt <= '0;
    end else if (i_en) begin
      r_cmt <= r_cmt | (i_commit & i_mask);
    end
  end

  assign o_all_done = (r_cmt == i_mask);

endmodule

// File: rtl/mpu_dispatch_ctrl.sv
// Dispatch sequencer: streams one thread program to the enabled TPUs and collects their commits.
// Optional watchdog on the commit wait is enabled with `define MPU_DISPATCH_WDOG_EN.
module mpu_dispatch_ctrl
  import pkg_mpu::*;
#(
  parameter int unsigned NUM_TPU = P_NUM_TPU,
  parameter int unsigned THID_W  = P_THID_W,
  parameter int unsigned LEN_W   = P_LEN_W,
  parameter int unsigned WDOG_W  = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               I_Req_Dispatch,
  input  logic [THID_W-1:0]  I_ThID,
  input  logic [LEN_W-1:0]   I_Base,
  input  logic [LEN_W-1:0]   I_Length,
  input  logic [NUM_TPU-1:0] I_En_TPU,
  output logic               O_Ack_Dispatch,
  output logic               O_Req_IMem,
  output logic [LEN_W-1:0]   O_Addr_IMem,
  output logic               O_Issue_V,
  output logic [NUM_TPU-1:0] O_En_Issue,
  output logic [THID_W-1:0]  O_ThID,
  input  logic [NUM_TPU-1:0] I_Stall_TPU,
  input  logic [NUM_TPU-1:0] I_Commit_TPU,
  output logic               O_Commit,
  output logic               O_Busy,
  output logic               O_Error
);

  dispatch_fsm_t    r_state, w_state_d;
  dispatch_req_t    r_req;
  logic [LEN_W-1:0] r_offset;
  logic             r_issue_v;

  logic w_ack, w_req_imem, w_commit;
  logic w_stall, w_empty, w_last, w_all_done, w_wdog_expire;

  assign w_stall = |(I_Stall_TPU & r_req.en_tpu);
  assign w_empty = (I_Length == '0) || (I_En_TPU == '0);
  assign w_last  = (r_offset == (r_req.length - LEN_W'(1)));

  always_comb begin
    w_state_d  = r_state;
    w_ack      = 1'b0;
    w_req_imem = 1'b0;
    w_commit   = 1'b0;
    case (r_state)
      IDLE: begin
        if (I_Req_Dispatch) begin
          w_ack     = 1'b1;
          w_state_d = w_empty ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (!w_stall) begin
          w_req_imem = 1'b1;
          if (w_last) w_state_d = WAIT_CMT;
        end
      end
      WAIT_CMT: begin
        if (w_all_done || w_wdog_expire) w_state_d = DONE;
      end
      DONE: begin
        w_commit  = 1'b1;
        w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_req     <= '0;
      r_offset  <= '0;
      r_issue_v <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_issue_v <= w_req_imem;
      if (w_ack) begin
        r_req    <= '{thid: I_ThID, base: I_Base, length: I_Length, en_tpu: I_En_TPU};
        r_offset <= '0;
      end else if (w_req_imem) begin
        r_offset <= r_offset + LEN_W'(1);
      end
    end
  end

  mpu_commit_collect #(
    .NUM_TPU (NUM_TPU)
  ) u_commit_collect (
    .clock      (clock),
    .reset      (reset),
    .i_en       ((r_state == ISSUE) || (r_state == WAIT_CMT)),
    .i_clr      (r_state == DONE),
    .i_mask     (r_req.en_tpu),
    .i_commit   (I_Commit_TPU),
    .o_all_done (w_all_done)
  );

`ifdef MPU_DISPATCH_WDOG_EN
  logic [WDOG_W-1:0] r_wdog;
  logic              r_err;

  // DONE is entered on the same edge the counter reaches all-ones.
  assign w_wdog_expire = (r_state == WAIT_CMT) &&
                         (r_wdog == ({WDOG_W{1'b1}} - WDOG_W'(1)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_wdog_expire && !w_all_done;
      if ((r_state == ISSUE) && (w_state_d == WAIT_CMT)) begin
        r_wdog <= '0;
      end else if (r_state == WAIT_CMT) begin
        r_wdog <= r_wdog + WDOG_W'(1);
      end
    end
  end

  assign O_Error = r_err;
`else
  // Watchdog absent: the commit wait never times out.
  assign w_wdog_expire = (WDOG_W == 0);
  assign O_Error       = 1'b0;
`endif

  assign O_Ack_Dispatch = w_ack;
  assign O_Req_IMem     = w_req_imem;
  assign O_Addr_IMem    = w_req_imem ? (r_req.base + r_offset) : '0;
  assign O_Issue_V      = r_issue_v;
  assign O_En_Issue     = r_req.en_tpu;
  assign O_ThID         = r_req.thid;
  assign O_Commit       = w_commit;
  assign O_Busy         = (r_state != IDLE) || w_ack;

endmodule

// File: tb/tb_mpu_dispatch_ctrl.sv
// Self-checking bench for mpu_dispatch_ctrl: transaction-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_mpu_dispatch_ctrl;

  localparam int NT = 16;
  localparam int TW = 8;
  localparam int LW = 10;
`ifdef MPU_DISPATCH_WDOG_EN
  localparam int WW   = 4;
  localparam bit WDOG = 1'b1;
`else
  localparam int WW   = 16;
  localparam bit WDOG = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          I_Req_Dispatch;
  logic [TW-1:0] I_ThID;
  logic [LW-1:0] I_Base, I_Length;
  logic [NT-1:0] I_En_TPU, I_Stall_TPU, I_Commit_TPU;
  logic          O_Ack_Dispatch, O_Req_IMem, O_Issue_V, O_Commit, O_Busy, O_Error;
  logic [LW-1:0] O_Addr_IMem;
  logic [NT-1:0] O_En_Issue;
  logic [TW-1:0] O_ThID;

  mpu_dispatch_ctrl #(
    .NUM_TPU (NT),
    .THID_W  (TW),
    .LEN_W   (LW),
    .WDOG_W  (WW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .I_Req_Dispatch (I_Req_Dispatch),
    .I_ThID         (I_ThID),
    .I_Base         (I_Base),
    .I_Length       (I_Length),
    .I_En_TPU       (I_En_TPU),
    .O_Ack_Dispatch (O_Ack_Dispatch),
    .O_Req_IMem     (O_Req_IMem),
    .O_Addr_IMem    (O_Addr_IMem),
    .O_Issue_V      (O_Issue_V),
    .O_En_Issue     (O_En_Issue),
    .O_ThID         (O_ThID),
    .I_Stall_TPU    (I_Stall_TPU),
    .I_Commit_TPU   (I_Commit_TPU),
    .O_Commit       (O_Commit),
    .O_Busy         (O_Busy),
    .O_Error        (O_Error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a dispatch is "len strobes, then wait for all lanes, then one commit".
  bit            m_active, m_commit_next, m_err_next, m_iv;
  int            m_sent, m_len, m_wait;
  logic [LW-1:0] m_base;
  logic [NT-1:0] m_mask, m_got;
  logic [TW-1:0] m_thid;

  bit            e_ack, e_req, e_commit, e_busy, e_err, e_iv;
  logic [LW-1:0] e_addr;
  logic [NT-1:0] e_en;
  logic [TW-1:0] e_thid;

  // Activity monitors read by the directed scenarios.
  int            n_strobe = 0, n_iv = 0, n_commit = 0, n_busy = 0, n_err = 0;
  logic [LW-1:0] addr_q[$];

  always @(negedge clock) begin
    if (!reset) begin
      m_active = 0; m_commit_next = 0; m_err_next = 0; m_iv = 0;
      m_sent = 0; m_len = 0; m_wait = 0;
      m_base = '0; m_mask = '0; m_got = '0; m_thid = '0;
      chk("reset_outputs", 32'({O_Ack_Dispatch, O_Req_IMem, O_Issue_V, O_Commit, O_Busy,
                                O_Error, O_En_Issue, O_ThID}), 32'h0);
    end else begin
      e_ack = 0; e_req = 0; e_commit = 0; e_err = 0; e_addr = '0;
      e_iv = m_iv; e_en = m_mask; e_thid = m_thid;
      e_busy = m_active || m_commit_next || I_Req_Dispatch;
      if (m_commit_next) begin
        e_commit = 1; e_err = m_err_next;
        m_commit_next = 0; m_err_next = 0; m_active = 0; m_got = '0;
      end else if (!m_active) begin
        if (I_Req_Dispatch) begin
          e_ack = 1;
          m_thid = I_ThID; m_base = I_Base; m_len = int'(I_Length); m_mask = I_En_TPU;
          m_sent = 0; m_wait = 0;
          if (I_Length == '0 || I_En_TPU == '0) m_commit_next = 1;
          else m_active = 1;
        end
      end else if (m_sent < m_len) begin
        if ((I_Stall_TPU & m_mask) == '0) begin
          e_req = 1;
          e_addr = m_base + LW'(m_sent);
          m_sent++;
        end
        m_got |= I_Commit_TPU & m_mask;
      end else begin
        if (m_got == m_mask) begin
          m_commit_next = 1;
        end else if (WDOG && m_wait == (1 << WW) - 2) begin
          m_commit_next = 1; m_err_next = 1;
        end
        m_wait++;
        m_got |= I_Commit_TPU & m_mask;
      end
      m_iv = e_req;

      chk("ack", 32'(O_Ack_Dispatch), 32'(e_ack));
      chk("req_imem", 32'(O_Req_IMem), 32'(e_req));
      if (e_req) chk("addr_imem", 32'(O_Addr_IMem), 32'(e_addr));
      chk("issue_v", 32'(O_Issue_V), 32'(e_iv));
      chk("en_issue", 32'(O_En_Issue), 32'(e_en));
      chk("thid", 32'(O_ThID), 32'(e_thid));
      chk("commit", 32'(O_Commit), 32'(e_commit));
      chk("busy", 32'(O_Busy), 32'(e_busy));
      chk("error", 32'(O_Error), 32'(e_err));

      if (O_Req_IMem) begin n_strobe++; addr_q.push_back(O_Addr_IMem); end
      if (O_Issue_V) n_iv++;
      if (O_Commit) n_commit++;
      if (O_Busy) n_busy++;
      if (O_Error) n_err++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic dispatch(input logic [TW-1:0] thid, input logic [LW-1:0] base,
                          input logic [LW-1:0] len, input logic [NT-1:0] en);
    I_ThID = thid; I_Base = base; I_Length = len; I_En_TPU = en;
    I_Req_Dispatch = 1'b1;
    step();
    I_Req_Dispatch = 1'b0;
  endtask

  task automatic wait_commit(input int s, input int max, input string name);
    for (int i = 0; i < max && n_commit == s; i++) step();
    chk(name, 32'(n_commit != s), 32'h1);
  endtask

  int s_str, s_iv, s_cmt, s_busy, s_err, q0;
  logic [LW-1:0] exp_t2[5];

  task automatic snap();
    s_str = n_strobe; s_iv = n_iv; s_cmt = n_commit; s_busy = n_busy; s_err = n_err;
    q0 = addr_q.size();
  endtask

  initial begin
    I_Req_Dispatch = 0; I_ThID = '0; I_Base = '0; I_Length = '0; I_En_TPU = '0;
    I_Stall_TPU = '0; I_Commit_TPU = '0;
    #1;
    chk("por_busy", 32'(O_Busy), 32'h0);
    chk("por_en_issue", 32'(O_En_Issue), 32'h0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) step();

    // T1: plain stream of 4 from 0x010, both lanes commit together
    snap();
    dispatch(8'h5A, 10'h010, 10'd4, 16'h0003);
    repeat (4) step();
    I_Commit_TPU = 16'h0003;
    step();
    I_Commit_TPU = '0;
    wait_commit(s_cmt, 10, "t1_commit_timeout");
    repeat (2) step();
    chk("t1_strobes", 32'(n_strobe - s_str), 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_addr", 32'(addr_q[q0 + i]), 32'h010 + 32'(i));
    chk("t1_issue_v", 32'(n_iv - s_iv), 32'd4);
    chk("t1_commits", 32'(n_commit - s_cmt), 32'd1);
    chk("t1_thid", 32'(O_ThID), 32'h5A);

    // T2: masked stall for two cycles, address wraps past 0x3FF
    snap();
    dispatch(8'h11, 10'h3FE, 10'd5, 16'h0001);
    step();
    I_Stall_TPU = 16'h0001;
    repeat (2) step();
    I_Stall_TPU = '0;
    repeat (6) step();
    I_Commit_TPU = 16'h0001;
    step();
    I_Commit_TPU = '0;
    wait_commit(s_cmt, 10, "t2_commit_timeout");
    repeat (2) step();
    exp_t2 = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h002};
    chk("t2_strobes", 32'(n_strobe - s_str), 32'd5);
    for (int i = 0; i < 5; i++) chk("t2_addr", 32'(addr_q[q0 + i]), 32'(exp_t2[i]));
    chk("t2_issue_v", 32'(n_iv - s_iv), 32'd5);
    chk("t2_commits", 32'(n_commit - s_cmt), 32'd1);

    // T3: stall on unmasked lane, mask/request changes mid-dispatch ignored
    snap();
    I_Stall_TPU = 16'h0020;
    dispatch(8'h22, 10'h100, 10'd3, 16'h0001);
    I_En_TPU = 16'hFFFF; I_ThID = 8'hEE; I_Req_Dispatch = 1'b1;
    I_Commit_TPU = 16'h0020;
    step();
    I_Req_Dispatch = 1'b0; I_Commit_TPU = '0;
    repeat (2) step();
    chk("t3_strobes", 32'(n_strobe - s_str), 32'd3);
    for (int i = 0; i < 3; i++) chk("t3_addr", 32'(addr_q[q0 + i]), 32'h100 + 32'(i));
    chk("t3_en_issue", 32'(O_En_Issue), 32'h0001);
    chk("t3_thid", 32'(O_ThID), 32'h22);
    I_Stall_TPU = '0;
    I_Commit_TPU = 16'h0001;
    step();
    I_Commit_TPU = '0;
    wait_commit(s_cmt, 10, "t3_commit_timeout");
    repeat (2) step();
    chk("t3_commits", 32'(n_commit - s_cmt), 32'd1);

    // T4: empty dispatches (Length 0, then mask 0)
    snap();
    dispatch(8'h33, 10'h055, 10'd0, 16'h0003);
    chk("t4a_commit_next", 32'(O_Commit), 32'h1);
    repeat (2) step();
    chk("t4a_busy", 32'(n_busy - s_busy), 32'd2);
    chk("t4a_strobes", 32'(n_strobe - s_str), 32'd0);
    chk("t4a_commits", 32'(n_commit - s_cmt), 32'd1);
    snap();
    dispatch(8'h34, 10'h055, 10'd5, 16'h0000);
    chk("t4b_commit_next", 32'(O_Commit), 32'h1);
    repeat (2) step();
    chk("t4b_busy", 32'(n_busy - s_busy), 32'd2);
    chk("t4b_strobes", 32'(n_strobe - s_str), 32'd0);
    chk("t4b_commits", 32'(n_commit - s_cmt), 32'd1);

    // T5: early commit on L1 during ISSUE, L0 twice during WAIT_CMT
    snap();
    dispatch(8'h44, 10'h200, 10'd4, 16'h0003);
    step();
    I_Commit_TPU = 16'h0002;
    step();
    I_Commit_TPU = '0;
    repeat (4) step();
    I_Commit_TPU = 16'h0001;
    step();
    chk("t5_no_commit_yet", 32'(O_Commit), 32'h0);
    step();
    I_Commit_TPU = '0;
    chk("t5_commit_cycle", 32'(O_Commit), 32'h1);
    repeat (3) step();
    chk("t5_commits", 32'(n_commit - s_cmt), 32'd1);

    // T6: asynchronous reset in the middle of ISSUE
    snap();
    dispatch(8'h66, 10'h000, 10'd8, 16'h00FF);
    step();
    #2 reset = 1'b0;
    #1;
    chk("t6_req_imem", 32'(O_Req_IMem), 32'h0);
    chk("t6_busy", 32'(O_Busy), 32'h0);
    chk("t6_en_issue", 32'(O_En_Issue), 32'h0);
    chk("t6_thid", 32'(O_ThID), 32'h0);
    @(posedge clock);
    #2 reset = 1'b1;
    repeat (4) step();
    chk("t6_no_commit", 32'(n_commit - s_cmt), 32'd0);
    snap();
    dispatch(8'h67, 10'h020, 10'd2, 16'h0001);
    chk("t6_relatch_thid", 32'(O_ThID), 32'h67);
    I_Commit_TPU = 16'h0001;
    step();
    I_Commit_TPU = '0;
    wait_commit(s_cmt, 10, "t6_commit_timeout");
    repeat (2) step();
    chk("t6_strobes", 32'(n_strobe - s_str), 32'd2);
    chk("t6_commits", 32'(n_commit - s_cmt), 32'd1);
    chk("t6_no_error", 32'(n_err - s_err), 32'd0);

`ifdef MPU_DISPATCH_WDOG_EN
    // T7: L1 never commits; watchdog ends the wait 15 cycles after WAIT_CMT entry
    snap();
    dispatch(8'h77, 10'h000, 10'd1, 16'h0003);
    step();
    I_Commit_TPU = 16'h0001;
    step();
    I_Commit_TPU = '0;
    repeat (14) step();
    chk("t7_error", 32'(O_Error), 32'h1);
    chk("t7_commit", 32'(O_Commit), 32'h1);
    repeat (2) step();
    chk("t7_error_count", 32'(n_err - s_err), 32'd1);
    chk("t7_commits", 32'(n_commit - s_cmt), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
